// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Build option: define AES_ENC_UNROLL2_EN for two rounds per cycle (7-cycle latency instead of 12).
module aes_encrypt_core #(
   parameter bit DONE_HOLD = 1'b1
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         AES_START,
   input  logic [127:0] AES_KEY,
   input  logic [127:0] AES_MSG_PT,
   output logic [127:0] AES_MSG_ENC,
   output logic         AES_DONE,
   output logic         AES_BUSY
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [127:0]  st_q, st_d;
   logic [127:0]  key_q, key_d;
   logic [127:0]  enc_q, enc_d;
   logic [7:0]    rcon_q, rcon_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [127:0]  ka;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   // SubBytes and ShiftRows together; byte k of the state is row k%4, column k/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] round_full(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      logic [127:0] o;
      t = sub_shift(s);
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
      end
      return o ^ k;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   assign ka = key_step(key_q, rcon_q);

`ifdef AES_ENC_UNROLL2_EN
   logic [127:0] kb;
   assign kb = key_step(ka, xtime(rcon_q));
`endif

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      key_d   = key_q;
      enc_d   = enc_q;
      rcon_d  = rcon_q;
      rnd_d   = rnd_q;
      case (state_q)
         S_IDLE: begin
            if (AES_START) begin
               st_d    = AES_MSG_PT;
               key_d   = AES_KEY;
               rcon_d  = 8'h01;
               rnd_d   = '0;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
`ifdef AES_ENC_UNROLL2_EN
            st_d   = round_full(st_q ^ key_q, ka);
`else
            st_d   = st_q ^ key_q;
`endif
            key_d   = ka;
            rcon_d  = xtime(rcon_q);
            rnd_d   = 4'd1;
            state_d = S_ROUND;
         end
         S_ROUND: begin
`ifdef AES_ENC_UNROLL2_EN
            // key_q trails the state by one key step: it holds rk[rnd] after a double round.
            st_d   = round_full(round_full(st_q, ka), kb);
            key_d  = kb;
            rcon_d = xtime(xtime(rcon_q));
            rnd_d  = rnd_q + 4'd2;
            if (rnd_q == 4'd7) state_d = S_FINAL;
`else
            st_d   = round_full(st_q, key_q);
            key_d  = ka;
            rcon_d = xtime(rcon_q);
            rnd_d  = rnd_q + 4'd1;
            if (rnd_q == 4'd9) state_d = S_FINAL;
`endif
         end
         S_FINAL: begin
`ifdef AES_ENC_UNROLL2_EN
            enc_d = sub_shift(st_q) ^ ka;
            key_d = ka;
            rnd_d = 4'd10;
`else
            enc_d = sub_shift(st_q) ^ key_q;
`endif
            st_d    = enc_d;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!DONE_HOLD || !AES_START) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         key_q   <= '0;
         enc_q   <= '0;
         rcon_q  <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         key_q   <= key_d;
         enc_q   <= enc_d;
         rcon_q  <= rcon_d;
         rnd_q   <= rnd_d;
      end
   end

   assign AES_MSG_ENC = enc_q;
   assign AES_DONE    = (state_q == S_DONE);
   assign AES_BUSY    = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
